// File: rtl/multi_string_driver.sv
// multi_string_driver: CHANNELS independent one-wire NRZ LED string outputs.
// Each channel owns a pixel FIFO and a bit-timing FSM; h_blank arms a latch
// gap on every channel at the end of a frame.
module multi_string_driver #(
    parameter int CHANNELS    = 2,
    parameter int PIXEL_WIDTH = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int T0H         = 35,
    parameter int T1H         = 70,
    parameter int T_BIT       = 125,
    parameter int T_LATCH     = 5000,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    input  logic [CH_W-1:0]        pixel_channel,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    input  logic                   h_blank,
    output logic [CHANNELS-1:0]    sdi,
    output logic [CHANNELS-1:0]    busy,
    output logic [CHANNELS-1:0]    underrun
);

    localparam int CNT_W = $clog2(T_LATCH + 1);
    localparam int BIT_W = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    logic [CHANNELS-1:0] full;

    // Ready reflects the addressed FIFO; an out-of-range channel is never ready.
    always_comb begin
        pixel_ready = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (pixel_channel == CH_W'(c)) begin
                pixel_ready = !full[c];
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [PIXEL_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]       wr_ptr_q;
        logic [PTR_W-1:0]       rd_ptr_q;
        logic [PTR_W:0]         count_q;
        logic [PTR_W:0]         count_d;
        state_t                 state_q;
        logic [CNT_W-1:0]       cyc_q;
        logic [BIT_W-1:0]       bit_q;
        logic [PIXEL_WIDTH-1:0] shreg_q;
        logic                   pending_q;
        logic                   in_frame_q;
        logic                   sdi_q;
        logic                   underrun_q;
        logic                   push;
        logic                   pop;
        logic                   empty;
        logic                   bit_end;
        logic [CNT_W-1:0]       high_len;

        assign push     = pixel_valid && pixel_ready && (pixel_channel == CH_W'(gi));
        assign empty    = (count_q == '0);
        assign full[gi] = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
        assign bit_end  = (cyc_q == CNT_W'(T_BIT - 1));
        assign high_len = shreg_q[PIXEL_WIDTH-1] ? CNT_W'(T1H) : CNT_W'(T0H);
        // A pixel is taken from the FIFO when idle, or at the end of the last
        // bit so that consecutive pixels run back to back.
        assign pop      = !empty && ((state_q == IDLE) ||
                          ((state_q == LOW) && bit_end && (bit_q == '0)));

        // FIFO occupancy follows push and pop, both of which may coincide.
        always_comb begin
            count_d = count_q;
            if (push && !pop) begin
                count_d = count_q + (PTR_W + 1)'(1);
            end else if (!push && pop) begin
                count_d = count_q - (PTR_W + 1)'(1);
            end
        end

        // Pixel storage; contents need no reset since pointers define validity.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= pixel_data;
            end
        end

        // FIFO pointers and occupancy count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
            end
        end

        // Bit-timing FSM; sdi is registered from the state, so it trails it by one cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= IDLE;
                cyc_q      <= '0;
                bit_q      <= '0;
                shreg_q    <= '0;
                pending_q  <= 1'b0;
                in_frame_q <= 1'b0;
                sdi_q      <= 1'b0;
                underrun_q <= 1'b0;
            end else begin
                underrun_q <= 1'b0;
                sdi_q      <= (state_q == HIGH);
                case (state_q)
                    IDLE: begin
                        cyc_q <= '0;
                        if (pop) begin
                            shreg_q    <= mem_q[rd_ptr_q];
                            bit_q      <= BIT_W'(PIXEL_WIDTH - 1);
                            in_frame_q <= 1'b1;
                            state_q    <= HIGH;
                        end else if (pending_q) begin
                            // Consumed on entry so an h_blank during the gap re-arms it.
                            pending_q <= 1'b0;
                            state_q   <= LATCH;
                        end
                    end
                    HIGH: begin
                        cyc_q <= cyc_q + CNT_W'(1);
                        if (cyc_q == high_len - CNT_W'(1)) begin
                            state_q <= LOW;
                        end
                    end
                    LOW: begin
                        if (!bit_end) begin
                            cyc_q <= cyc_q + CNT_W'(1);
                        end else begin
                            cyc_q <= '0;
                            if (bit_q != '0) begin
                                bit_q   <= bit_q - BIT_W'(1);
                                shreg_q <= {shreg_q[PIXEL_WIDTH-2:0], 1'b0};
                                state_q <= HIGH;
                            end else if (pop) begin
                                shreg_q <= mem_q[rd_ptr_q];
                                bit_q   <= BIT_W'(PIXEL_WIDTH - 1);
                                state_q <= HIGH;
                            end else if (pending_q) begin
                                pending_q <= 1'b0;
                                state_q   <= LATCH;
                            end else begin
                                underrun_q <= in_frame_q;
                                state_q    <= IDLE;
                            end
                        end
                    end
                    LATCH: begin
                        if (cyc_q == CNT_W'(T_LATCH - 1)) begin
                            cyc_q      <= '0;
                            in_frame_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            cyc_q <= cyc_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                // h_blank takes priority over the consume above.
                if (h_blank) begin
                    pending_q <= 1'b1;
                end
            end
        end

        assign sdi[gi]      = sdi_q;
        assign underrun[gi] = underrun_q;
        assign busy[gi]     = !empty || (state_q != IDLE);
    end

endmodule

// File: tb/tb_multi_string_driver.sv
// Testbench for multi_string_driver: directed scenarios with random pixel data,
// per-cycle recording and comparison against an expected waveform timeline.
module tb_multi_string_driver;
    localparam int CH  = 2;
    localparam int PW  = 8;
    localparam int FD  = 4;
    localparam int T0H = 2;
    localparam int T1H = 4;
    localparam int TB  = 6;
    localparam int TL  = 20;
    localparam int CW  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] pixel_data = '0;
    logic [CW-1:0] pixel_channel = '0;
    logic          pixel_valid = 1'b0;
    logic          pixel_ready;
    logic          h_blank = 1'b0;
    logic [CH-1:0] sdi;
    logic [CH-1:0] busy;
    logic [CH-1:0] underrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [CH-1:0] sdi_h[$];
    logic [CH-1:0] busy_h[$];
    logic [CH-1:0] und_h[$];
    logic          exp_w[$];

    logic [PW-1:0] px[6];

    always #5 clk = ~clk;

    multi_string_driver #(
        .CHANNELS(CH), .PIXEL_WIDTH(PW), .FIFO_DEPTH(FD), .T0H(T0H),
        .T1H(T1H), .T_BIT(TB), .T_LATCH(TL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data),
        .pixel_channel(pixel_channel), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .h_blank(h_blank), .sdi(sdi),
        .busy(busy), .underrun(underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and record the outputs of the edge just passed.
    task automatic tick_rec();
        @(negedge clk);
        sdi_h.push_back(sdi);
        busy_h.push_back(busy);
        und_h.push_back(underrun);
    endtask

    task automatic step(input logic v, input logic [CW-1:0] c, input logic [PW-1:0] d, input logic hb);
        pixel_valid   = v;
        pixel_channel = c;
        pixel_data    = d;
        h_blank       = hb;
        tick_rec();
        pixel_valid = 1'b0;
        h_blank     = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick_rec();
    endtask

    task automatic clear_hist();
        sdi_h.delete();
        busy_h.delete();
        und_h.delete();
        exp_w.delete();
    endtask

    task automatic add_zeros(input int n);
        for (int i = 0; i < n; i++) exp_w.push_back(1'b0);
    endtask

    // One pixel on the wire: MSB first, each bit T_BIT long, high for T0H/T1H.
    task automatic add_pixel(input logic [PW-1:0] d);
        int hi;
        for (int b = PW - 1; b >= 0; b--) begin
            hi = d[b] ? T1H : T0H;
            for (int c = 0; c < TB; c++) exp_w.push_back(c < hi);
        end
    endtask

    task automatic check_sdi(input string tag, input int ch, input bit use_exp);
        logic e;
        for (int t = 0; t < sdi_h.size(); t++) begin
            e = (use_exp && t < exp_w.size()) ? exp_w[t] : 1'b0;
            chk($sformatf("%s sdi%0d t=%0d", tag, ch, t), 32'(sdi_h[t][ch]), 32'(e));
        end
    endtask

    task automatic check_busy(input string tag, input int ch, input int lo1, input int hi1,
                              input int lo2, input int hi2);
        logic e;
        for (int t = 0; t < busy_h.size(); t++) begin
            e = (t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2);
            chk($sformatf("%s busy%0d t=%0d", tag, ch, t), 32'(busy_h[t][ch]), 32'(e));
        end
    endtask

    task automatic check_und(input string tag, input int ch, input int n);
        int cnt;
        cnt = 0;
        for (int t = 0; t < und_h.size(); t++) if (und_h[t][ch] === 1'b1) cnt++;
        chk($sformatf("%s und%0d_count", tag, ch), 32'(cnt), 32'(n));
    endtask

    task automatic check_ready(input string tag, input logic [CW-1:0] c, input logic exp);
        pixel_channel = c;
        #1;
        chk($sformatf("%s ready ch%0d", tag, c), 32'(pixel_ready), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < 6; i++) px[i] = PW'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst sdi", 32'(sdi), 32'(0));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst underrun", 32'(underrun), 32'(0));
        check_ready("rst", 1'b0, 1'b1);
        check_ready("rst", 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_ticks(3);

        // Idle h_blank with empty FIFOs: latch on both channels one cycle later
        clear_hist();
        step(1'b0, 1'b0, '0, 1'b1);
        idle_ticks(30);
        for (int c = 0; c < CH; c++) begin
            check_sdi("idle_hb", c, 1'b0);
            check_busy("idle_hb", c, 1, TL, 1, 0);
            check_und("idle_hb", c, 0);
        end

        // Single pixel on ch0, ends in an underrun
        clear_hist();
        step(1'b1, 1'b0, px[0], 1'b0);
        idle_ticks(60);
        add_zeros(2);
        add_pixel(px[0]);
        check_sdi("single", 0, 1'b1);
        check_sdi("single", 1, 1'b0);
        check_busy("single", 0, 0, PW * TB, 1, 0);
        check_busy("single", 1, 1, 0, 1, 0);
        check_und("single", 0, 1);
        check_und("single", 1, 0);
        chk("single und_pos", 32'(und_h[PW * TB + 1][0]), 32'(1));

        // Back-to-back FF, 00 on ch1 then h_blank: contiguous bits then latch
        clear_hist();
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        idle_ticks(128);
        add_zeros(2);
        add_pixel(8'hFF);
        add_pixel(8'h00);
        check_sdi("b2b", 1, 1'b1);
        check_sdi("b2b", 0, 1'b0);
        check_busy("b2b", 1, 0, 2 * PW * TB + TL, 1, 0);
        check_busy("b2b", 0, 3, 2 + TL, 1, 0);
        check_und("b2b", 1, 0);
        check_und("b2b", 0, 0);

        // Full FIFO on ch0: one in flight plus four buffered, the fifth dropped
        clear_hist();
        step(1'b1, 1'b0, px[0], 1'b0);
        step(1'b1, 1'b0, px[1], 1'b0);
        step(1'b1, 1'b0, px[2], 1'b0);
        step(1'b1, 1'b0, px[3], 1'b0);
        check_ready("fill3", 1'b0, 1'b1);
        step(1'b1, 1'b0, px[4], 1'b0);
        check_ready("full", 1'b0, 1'b0);
        check_ready("full", 1'b1, 1'b1);
        step(1'b1, 1'b0, px[5], 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        idle_ticks(273);
        add_zeros(2);
        for (int i = 0; i < 5; i++) add_pixel(px[i]);
        check_sdi("full", 0, 1'b1);
        check_sdi("full", 1, 1'b0);
        check_busy("full", 0, 0, 5 * PW * TB + TL, 1, 0);
        check_busy("full", 1, 7, 6 + TL, 1, 0);
        check_und("full", 0, 0);

        // h_blank and a write during the latch gap on ch0
        clear_hist();
        step(1'b1, 1'b0, px[1], 1'b1);
        idle_ticks(54);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, px[2], 1'b0);
        idle_ticks(93);
        add_zeros(2);
        add_pixel(px[1]);
        add_zeros(21);
        add_pixel(px[2]);
        check_sdi("relatch", 0, 1'b1);
        check_sdi("relatch", 1, 1'b0);
        check_busy("relatch", 0, 0, 2 * PW * TB + 2 * TL + 1, 1, 0);
        check_busy("relatch", 1, 1, TL, 56, 55 + TL);
        check_und("relatch", 0, 0);
        check_und("relatch", 1, 0);

        // Reset in the middle of a high phase
        clear_hist();
        step(1'b1, 1'b1, px[3] | 8'h80, 1'b0);
        step(1'b1, 1'b1, px[4], 1'b0);
        step(1'b1, 1'b0, px[5], 1'b0);
        chk("pre_rst sdi1", 32'(sdi[1]), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst sdi", 32'(sdi), 32'(0));
        chk("mid_rst busy", 32'(busy), 32'(0));
        check_ready("mid_rst", 1'b0, 1'b1);
        check_ready("mid_rst", 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_hist();
        idle_ticks(60);
        for (int c = 0; c < CH; c++) begin
            check_sdi("post_rst", c, 1'b0);
            check_busy("post_rst", c, 1, 0, 1, 0);
            check_und("post_rst", c, 0);
        end
        clear_hist();
        step(1'b1, 1'b1, px[0], 1'b0);
        idle_ticks(60);
        add_zeros(2);
        add_pixel(px[0]);
        check_sdi("after_rst", 1, 1'b1);
        check_sdi("after_rst", 0, 1'b0);
        check_busy("after_rst", 1, 0, PW * TB, 1, 0);
        check_und("after_rst", 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
